instr_mem_ld: RTL
=================

Name: instr_mem_ld

Overview:
- Parametrised, run-time loadable instruction memory feeding the Decoder.
- Successor to the fixed read-only instruction store: width and depth are parameters, and the program is written through a valid/ready load stream.
- Fetch reads are registered, with an explicit valid, and are blocked while a load is in progress.
- Sits between ProgramCnt (fetch side) and the host/config loader (load side).

Parameters:
- INSTR_W, 32, instruction width in bits
- ADDR_W, 8, address width
- DEPTH, 256, number of words, DEPTH <= 2**ADDR_W
- INSTR_NOP, 0, value returned for an out-of-range fetch

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- load_start  in  1  pulse: begin a load at load_base
- load_base  in  ADDR_W  first write address, sampled with load_start
- load_valid  in  1  load beat valid
- load_data  in  INSTR_W  load beat data
- load_last  in  1  final beat of the load
- load_ready  out  1  loader accepts a beat
- fetch_req  in  1  fetch request from ProgramCnt
- fetch_addr  in  ADDR_W  fetch address
- fetch_ready  out  1  fetch accepted
- instr  out  INSTR_W  instruction to the Decoder
- instr_valid  out  1  instr is valid this cycle
- loaded  out  1  a complete program is resident
- load_err  out  1  sticky flag: write pointer wrapped during a load

Behaviour:
- Reset state is IDLE. All outputs reset to 0; the write pointer (wptr) resets to 0. Memory contents are not reset.
- FSM states: IDLE, LOAD, RUN.
- IDLE:
  - load_ready=0, fetch_ready=0.
  - load_start -> LOAD; wptr<=load_base; load_err<=0.
- LOAD:
  - load_ready=1, fetch_ready=0.
  - On load_valid&load_ready: mem[wptr]<=load_data; wptr<=wptr+1.
  - If wptr==DEPTH-1 and the beat is not last: wptr wraps to 0 and load_err<=1 (sticky until the next load_start).
  - Accepted beat with load_last=1 -> RUN in the next cycle; loaded<=1.
  - load_start during LOAD is ignored.
- RUN:
  - fetch_ready=1, load_ready=0.
  - fetch_req accepted at cycle N -> instr=mem[fetch_addr] with instr_valid=1 at cycle N+1. Latency is 1 and throughput is 1 per cycle.
  - fetch_addr>=DEPTH returns INSTR_NOP, still with instr_valid=1.
  - Without fetch_req, instr_valid=0 and instr holds its last value.
- load_start in RUN -> LOAD; loaded<=0; fetch_ready drops in the same cycle (combinational from the state plus load_start). A fetch_req in that cycle is not accepted and produces no instr_valid.
- fetch_req in IDLE or LOAD is not accepted (fetch_ready=0). ProgramCnt must hold the request.
- Reset mid-load: return to IDLE, loaded=0, load_err=0. Words already written stay in memory but are not trusted.
- Write and read never coincide, because the states are exclusive. No read-during-write rule is needed.
- wptr arithmetic is ADDR_W-bit, modulo DEPTH.

Optional Feature:
- Macro INSTR_PARITY_EN.
- With it defined:
  - Memory words are INSTR_W+1 bits, storing the even parity of load_data.
  - Extra output port parity_err (1 bit), asserted in the same cycle as instr_valid when the stored parity mismatches; reset value 0.
  - INSTR_NOP reads have parity_err=0.
- Without it: no parity bit, and no parity_err port.

Decomposition:
- Shared package/define file (define.v): InstrLength and InstrMemDepth default constants, the FSM state encodings (IDLE=2'd0, LOAD=2'd1, RUN=2'd2), and the INSTR_NOP default.
- One sub-module, instr_ram_sp:
  - Single-port synchronous RAM, parametrised width and depth.
  - Write enable, registered read, no reset on the array.
  - instr_mem_ld muxes the address between wptr and fetch_addr by state.

Test Plan:
- Reset then fetch: after rst_n release, fetch_req=1 addr=0 -> fetch_ready=0, instr_valid stays 0, loaded=0.
- Basic load/fetch (DEPTH=256):
  - Stimulus: load_start base=0x10, beats 0xA0000001, 0xA0000002, 0xA0000003 with last on the third, then fetch 0x10, 0x11, 0x12 back-to-back.
  - Response: loaded=1 one cycle after the last beat; instr 0xA0000001..3 on three consecutive cycles with instr_valid=1, each one cycle after its request.
- Backpressure/gaps: load_valid toggled 1,0,1,1 -> exactly 3 writes, wptr=base+3, no duplicates.
- Wrap error: load_base=0xFE with 4 beats (last on the 4th) -> writes to 0xFE, 0xFF, 0x00, 0x01; load_err=1; fetch 0x01 returns the 4th beat.
- Out of range and reload:
  - Stimulus 1: DEPTH=200, fetch 0xC8.
  - Response 1: instr=INSTR_NOP, instr_valid=1.
  - Stimulus 2: load_start with fetch_req in the same cycle.
  - Response 2: fetch not accepted, loaded drops to 0 next cycle.
- Reset mid-load: rst_n low after 2 of 5 beats -> IDLE, loaded=0, load_err=0; a new load_start is accepted normally.
- Parity (INSTR_PARITY_EN defined): force a single-bit flip in the RAM array at 0x10, fetch 0x10 -> parity_err=1 together with instr_valid.

Source files
------------

// File: rtl/instr_mem_ld_pkg.sv
// -----------------------------------------------------------------------------
// instr_mem_ld_pkg
//   Shared constants for the loadable instruction memory:
//     - default instruction width / memory depth / address width
//     - FSM state encoding (IDLE=0, LOAD=1, RUN=2)
//     - default value returned for an out-of-range fetch
// -----------------------------------------------------------------------------
package instr_mem_ld_pkg;

  localparam int INSTR_LENGTH    = 32;
  localparam int INSTR_MEM_DEPTH = 256;
  localparam int INSTR_ADDR_W    = 8;

  localparam logic [INSTR_LENGTH-1:0] INSTR_NOP_DEF = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage : instr_mem_ld_pkg

// File: rtl/instr_mem_ld_ram_sp.sv
// -----------------------------------------------------------------------------
// instr_ram_sp
//   Single-port synchronous RAM with write enable and a registered read port.
//   Ports:
//     clk    in   clock, rising edge
//     rst_n  in   async active-low reset (read register only)
//     we     in   write enable: mem[addr] <= wdata
//     re     in   read enable:  rdata <= mem[addr] on the next edge
//     addr   in   shared read/write address
//     wdata  in   write data
//     rdata  out  registered read data, holds while re is low
// -----------------------------------------------------------------------------
module instr_ram_sp #(
  parameter int W      = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [W-1:0]      wdata,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; only the
  // output register below is reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule : instr_ram_sp

// File: rtl/instr_mem_ld.sv
// -----------------------------------------------------------------------------
// instr_mem_ld
//   Run-time loadable instruction memory between ProgramCnt (fetch side) and
//   the host loader (load side). A program is written through a valid/ready
//   stream starting at load_base; fetches are accepted only once a complete
//   program is resident (RUN) and return data one cycle later.
//
//   Optional feature (macro INSTR_PARITY_EN): each word stores an extra even
//   parity bit and the output parity_err flags a mismatch on read.
//
//   Ports:
//     clk, rst_n          clock / async active-low reset
//     load_start          begin a load at load_base (IDLE or RUN)
//     load_base           first write address
//     load_valid/ready    load beat handshake
//     load_data/last      beat payload / final beat marker
//     fetch_req/addr      fetch request from ProgramCnt
//     fetch_ready         fetch accepted this cycle
//     instr/instr_valid   fetched instruction, valid one cycle after accept
//     loaded              a complete program is resident
//     load_err            sticky: write pointer wrapped during a load
//     parity_err          (INSTR_PARITY_EN only) stored parity mismatch
// -----------------------------------------------------------------------------
module instr_mem_ld
  import instr_mem_ld_pkg::*;
#(
  parameter int                 INSTR_W   = INSTR_LENGTH,
  parameter int                 ADDR_W    = INSTR_ADDR_W,
  parameter int                 DEPTH     = INSTR_MEM_DEPTH,
  parameter logic [INSTR_W-1:0] INSTR_NOP = INSTR_W'(INSTR_NOP_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_start,
  input  logic [ADDR_W-1:0]  load_base,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  output logic               load_ready,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic               fetch_ready,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               loaded,
  output logic               load_err
`ifdef INSTR_PARITY_EN
  ,
  output logic               parity_err
`endif
);

`ifdef INSTR_PARITY_EN
  localparam int MEM_W = INSTR_W + 1;
`else
  localparam int MEM_W = INSTR_W;
`endif

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  wptr_q;
  logic               beat;
  logic               accept;
  logic               in_range;
  logic               wptr_in_range;
  logic               wptr_at_end;
  logic               oor_q;
  logic               ram_we;
  logic               ram_re;
  logic [ADDR_W-1:0]  ram_addr;
  logic [MEM_W-1:0]   ram_wdata;
  logic [MEM_W-1:0]   ram_rdata;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    load_ready  = 1'b0;
    fetch_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_start) state_d = LOAD;
      end
      LOAD: begin
        load_ready = 1'b1;
        if (load_valid && load_last) state_d = RUN;
      end
      RUN: begin
        // A reload request pre-empts any fetch in the same cycle.
        fetch_ready = !load_start;
        if (load_start) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  assign beat          = load_valid & load_ready;
  assign accept        = fetch_req & fetch_ready;
  assign in_range      = int'(fetch_addr) < DEPTH;
  assign wptr_in_range = int'(wptr_q) < DEPTH;
  assign wptr_at_end   = wptr_q == ADDR_W'(DEPTH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      loaded      <= 1'b0;
      load_err    <= 1'b0;
      instr_valid <= 1'b0;
      oor_q       <= 1'b0;
    end else begin
      instr_valid <= accept;
      if (accept) oor_q <= !in_range;

      if (load_start && state_q != LOAD) begin
        wptr_q   <= load_base;
        load_err <= 1'b0;
        loaded   <= 1'b0;
      end else if (beat) begin
        // Pointer runs modulo DEPTH; wrapping before the last beat means the
        // program overwrote its own start.
        wptr_q <= wptr_at_end ? '0 : wptr_q + 1'b1;
        if (wptr_at_end && !load_last) load_err <= 1'b1;
        if (load_last) loaded <= 1'b1;
      end
    end
  end

  // Write and read are confined to LOAD and RUN respectively, so one address
  // port is shared. Out-of-range addresses never touch the array.
  assign ram_addr = (state_q == LOAD) ? wptr_q : fetch_addr;
  assign ram_we   = beat & wptr_in_range;
  assign ram_re   = accept & in_range;

`ifdef INSTR_PARITY_EN
  assign ram_wdata = {^load_data, load_data};
`else
  assign ram_wdata = load_data;
`endif

  instr_ram_sp #(
    .W      (MEM_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Both rdata and oor_q hold between accepted fetches, so instr holds too.
  assign instr = oor_q ? INSTR_NOP : ram_rdata[INSTR_W-1:0];

`ifdef INSTR_PARITY_EN
  // Stored word plus parity bit must reduce to 0 under even parity.
  assign parity_err = instr_valid & ~oor_q & (^ram_rdata);
`endif

endmodule : instr_mem_ld
